// File: rtl/usb_cmd_ctrl.sv
// Command controller on the USB download byte path: parses framed 32-bit config writes and drives capture control.
// Optional build macro CMD_CSUM_EN appends an XOR checksum byte to every frame.
module usb_cmd_ctrl #(
  parameter logic [7:0]  SYNC_BYTE = 8'hA5,
  parameter logic [15:0] TIMEOUT   = 16'd1024,
  parameter logic [3:0]  CTRL_ADDR = 4'hF
) (
  input  logic        IFCLK,
  input  logic        RST,
  input  logic        DOWNWR,
  input  logic [7:0]  DOWNDATA,
  output logic        DOWNBSY,
  output logic        CFG_WE,
  output logic [3:0]  CFG_ADDR,
  output logic [31:0] CFG_DATA,
  output logic        CAP_EN,
  output logic        CAP_RST,
  output logic [7:0]  ERR_CNT
);

  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_DATA, S_CSUM, S_COMMIT} state_t;

  state_t      state;
  logic [1:0]  idx;
  logic [3:0]  addr_q;
  logic [31:0] data_q;
  logic [31:0] data_nxt;
  logic [31:0] commit_data;
  logic [15:0] gap;
  logic        accept;
  logic        in_frame;
  logic        timeout_hit;
  logic        addr_bad;
  logic        csum_bad;
  logic        commit_go;
`ifdef CMD_CSUM_EN
  logic [7:0]  csum_q;
`endif

  assign accept      = DOWNWR && !DOWNBSY;
  assign in_frame    = (state == S_ADDR) || (state == S_DATA) || (state == S_CSUM);
  // An accepted byte always beats a coincident timeout.
  assign timeout_hit = in_frame && !accept && (gap == TIMEOUT - 16'd1);
  assign addr_bad    = accept && (state == S_ADDR) && (DOWNDATA[7:4] != 4'h0);

  // NOTE: every variable written in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    data_nxt = data_q;
    if (accept && (state == S_DATA))
      data_nxt[{idx, 3'b000} +: 8] = DOWNDATA;
  end

`ifdef CMD_CSUM_EN
  assign csum_bad    = accept && (state == S_CSUM) && (DOWNDATA != csum_q);
  assign commit_go   = accept && (state == S_CSUM) && (DOWNDATA == csum_q);
  assign commit_data = data_q;
`else
  assign csum_bad    = 1'b0;
  assign commit_go   = accept && (state == S_DATA) && (idx == 2'd3);
  assign commit_data = data_nxt;
`endif

  // NOTE: sequential state uses non-blocking assignments only; later assignments in the block take priority.
  always_ff @(posedge IFCLK) begin
    if (RST) begin
      state    <= S_IDLE;
      idx      <= 2'd0;
      addr_q   <= 4'h0;
      data_q   <= 32'h0;
      gap      <= 16'h0;
      DOWNBSY  <= 1'b0;
      CFG_WE   <= 1'b0;
      CFG_ADDR <= 4'h0;
      CFG_DATA <= 32'h0;
      CAP_EN   <= 1'b0;
      CAP_RST  <= 1'b0;
      ERR_CNT  <= 8'h0;
`ifdef CMD_CSUM_EN
      csum_q   <= 8'h0;
`endif
    end else begin
      DOWNBSY <= 1'b0;
      CFG_WE  <= 1'b0;
      CAP_RST <= 1'b0;
      data_q  <= data_nxt;

      if ((timeout_hit || addr_bad || csum_bad) && (ERR_CNT != 8'hFF))
        ERR_CNT <= ERR_CNT + 8'd1;

      if (accept || (state == S_IDLE))
        gap <= 16'h0;
      else if (in_frame)
        gap <= gap + 16'd1;

      case (state)
        S_IDLE: if (accept && (DOWNDATA == SYNC_BYTE)) state <= S_ADDR;
        S_ADDR:
          if (accept) begin
            if (addr_bad) begin
              state <= S_IDLE;
            end else begin
              addr_q <= DOWNDATA[3:0];
              idx    <= 2'd0;
              state  <= S_DATA;
`ifdef CMD_CSUM_EN
              csum_q <= DOWNDATA;
`endif
            end
          end
        S_DATA:
          if (accept) begin
            idx <= idx + 2'd1;
`ifdef CMD_CSUM_EN
            csum_q <= csum_q ^ DOWNDATA;
            if (idx == 2'd3) state <= S_CSUM;
`endif
          end
        S_CSUM:   if (accept) state <= S_IDLE;
        S_COMMIT: state <= S_IDLE;
        default:  state <= S_IDLE;
      endcase

      if (timeout_hit)
        state <= S_IDLE;

      // Last byte of a good frame: publish the write and any capture-control side effects together.
      if (commit_go) begin
        state    <= S_COMMIT;
        DOWNBSY  <= 1'b1;
        CFG_WE   <= 1'b1;
        CFG_ADDR <= addr_q;
        CFG_DATA <= commit_data;
        if (addr_q == CTRL_ADDR) begin
          CAP_EN  <= commit_data[0];
          CAP_RST <= commit_data[1];
        end
      end
    end
  end

endmodule
